// File: rtl/ci_pkg.sv
// ci_pkg: shared definitions for the custom-instruction issue controller.
//   - ci_state_e      : controller FSM states
//   - CiDataWDefault  : default operand/result width
//   - CiNWDefault     : default width of the CI function select
//   - TIMEOUT_DISABLED: watchdog setting that turns the timeout off
package ci_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } ci_state_e;

  localparam int unsigned CiDataWDefault   = 32;
  localparam int unsigned CiNWDefault      = 8;
  localparam int unsigned TIMEOUT_DISABLED = 0;

endpackage

// File: rtl/ci_watchdog.sv
// ci_watchdog: clearable, enabled up-counter with a terminal flag.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, clears the count
//   clr_i    : synchronous clear (has priority over en_i)
//   en_i     : count this cycle
//   expire_o : this enabled cycle is the TIMEOUT-th since the last clear
//
// expire_o is combinational so the caller can abort in the same cycle the
// count would reach TIMEOUT. With TIMEOUT == TIMEOUT_DISABLED it never fires.
module ci_watchdog
  import ci_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // Counts 0..TIMEOUT-1; the TIMEOUT-th enabled cycle raises expire_o.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Term = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT != TIMEOUT_DISABLED) && en_i && (cnt_q == Term);

endmodule

// File: rtl/ci_issue_ctrl.sv
// ci_issue_ctrl: initiator side of the Nios custom-instruction multicycle
// interface, so fabric masters can drive CI accelerators without the CPU.
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake (one outstanding op)
//   cmd_n/cmd_dataa/cmd_datab    : function select and operands
//   rsp_valid/rsp_ready          : response handshake
//   rsp_result/rsp_timeout       : result (0 on abort) and abort flag
//   hold                         : stall request, drops ci_clk_en
//   ci_clk_en/ci_start           : CI slave control
//   ci_n/ci_dataa/ci_datab       : registered operands to the slave
//   ci_result/ci_done            : slave result and completion
//   busy                         : controller not idle
//   ops_cnt/tmo_cnt              : completed / timed-out op counters (wrap)
//
// Flow: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. A combinational slave that
// raises ci_done during ISSUE skips WAIT. Dropping clk_en flushes the slave's
// sequencer, so a hold in WAIT returns to ISSUE to re-start the same op.
module ci_issue_ctrl
  import ci_pkg::*;
#(
  parameter int unsigned DATA_W  = CiDataWDefault,
  parameter int unsigned N_W     = CiNWDefault,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  // Command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N_W-1:0]    cmd_n,
  input  logic [DATA_W-1:0] cmd_dataa,
  input  logic [DATA_W-1:0] cmd_datab,
  // Response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_timeout,
  // Stall
  input  logic              hold,
  // CI slave interface
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [N_W-1:0]    ci_n,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  // Status
  output logic              busy,
  output logic [CNT_W-1:0]  ops_cnt,
  output logic [CNT_W-1:0]  tmo_cnt
);

  ci_state_e         state_q, state_d;
  logic [N_W-1:0]    ci_n_q, ci_n_d;
  logic [DATA_W-1:0] ci_dataa_q, ci_dataa_d;
  logic [DATA_W-1:0] ci_datab_q, ci_datab_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  ops_cnt_q, ops_cnt_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  ci_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Next-state and datapath.
  always_comb begin
    state_d       = state_q;
    ci_n_d        = ci_n_q;
    ci_dataa_d    = ci_dataa_q;
    ci_datab_d    = ci_datab_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    ops_cnt_d     = ops_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ci_n_d     = cmd_n;
          ci_dataa_d = cmd_dataa;
          ci_datab_d = cmd_datab;
          state_d    = StIssue;
        end
      end

      StIssue: begin
        // With hold high, start stays asserted but the slave is not clocked.
        if (!hold) begin
          if (ci_done) begin
            rsp_result_d  = ci_result;
            rsp_timeout_d = 1'b0;
            state_d       = StResp;
          end else begin
            wd_clr  = 1'b1;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (hold) begin
          // Slave flushes while clk_en is low: re-issue the held operands.
          state_d = StIssue;
        end else if (ci_done) begin
          // Done has priority over a coinciding watchdog expiry.
          rsp_result_d  = ci_result;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else begin
          wd_en = 1'b1;
          if (wd_expire) begin
            rsp_result_d  = '0;
            rsp_timeout_d = 1'b1;
            state_d       = StResp;
          end
        end
      end

      StResp: begin
        if (rsp_ready) begin
          ops_cnt_d = ops_cnt_q + 1'b1;
          if (rsp_timeout_q) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ci_n_q        <= '0;
      ci_dataa_q    <= '0;
      ci_datab_q    <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      ops_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ci_n_q        <= ci_n_d;
      ci_dataa_q    <= ci_dataa_d;
      ci_datab_q    <= ci_datab_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      ops_cnt_q     <= ops_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  // Control outputs decode the state register; clk_en also follows hold.
  assign cmd_ready   = (state_q == StIdle);
  assign ci_start    = (state_q == StIssue);
  assign ci_clk_en   = ((state_q == StIssue) || (state_q == StWait)) && !hold;
  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);

  assign ci_n        = ci_n_q;
  assign ci_dataa    = ci_dataa_q;
  assign ci_datab    = ci_datab_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign ops_cnt     = ops_cnt_q;
  assign tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_ci_issue_ctrl.sv
// Bench for ci_issue_ctrl with a behavioural multicycle CI slave.
module tb_ci_issue_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 8;
  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [NW-1:0] cmd_n = '0;
  logic [DW-1:0] cmd_dataa = '0;
  logic [DW-1:0] cmd_datab = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_timeout;
  logic          hold = 1'b0;
  logic          ci_clk_en;
  logic          ci_start;
  logic [NW-1:0] ci_n;
  logic [DW-1:0] ci_dataa;
  logic [DW-1:0] ci_datab;
  logic [DW-1:0] ci_result;
  logic          ci_done;
  logic          busy;
  logic [CW-1:0] ops_cnt;
  logic [CW-1:0] tmo_cnt;

  ci_issue_ctrl #(
    .DATA_W  (DW),
    .N_W     (NW),
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_n       (cmd_n),
    .cmd_dataa   (cmd_dataa),
    .cmd_datab   (cmd_datab),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_timeout (rsp_timeout),
    .hold        (hold),
    .ci_clk_en   (ci_clk_en),
    .ci_start    (ci_start),
    .ci_n        (ci_n),
    .ci_dataa    (ci_dataa),
    .ci_datab    (ci_datab),
    .ci_result   (ci_result),
    .ci_done     (ci_done),
    .busy        (busy),
    .ops_cnt     (ops_cnt),
    .tmo_cnt     (tmo_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: n==1 is a right shift, anything else XOR.
  function automatic logic [DW-1:0] slave_fn(input logic [NW-1:0] n, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    if (n == 8'h01) return a >> b[4:0];
    return a ^ b;
  endfunction

  // Multicycle slave: done in the lat-th enabled cycle after an enabled start;
  // clk_en low flushes it.
  int   lat = 3;
  bit   comb_mode = 1'b0;
  bit   never_done = 1'b0;
  logic sl_active;
  int   sl_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sl_active <= 1'b0;
      sl_cnt    <= 0;
    end else if (!ci_clk_en) begin
      sl_active <= 1'b0;
    end else if (ci_start) begin
      sl_active <= 1'b1;
      sl_cnt    <= 1;
    end else if (sl_active) begin
      sl_cnt <= sl_cnt + 1;
    end
  end

  assign ci_result = slave_fn(ci_n, ci_dataa, ci_datab);
  assign ci_done   = never_done ? 1'b0 : (comb_mode ? ci_start : (sl_active && sl_cnt == lat));

  // Monitors: start rising edges and enabled WAIT cycles.
  int   start_rises = 0;
  int   wait_cyc = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    start_prev <= ci_start;
    if (ci_start && !start_prev) start_rises <= start_rises + 1;
    if (busy && !ci_start && !rsp_valid && ci_clk_en) wait_cyc <= wait_cyc + 1;
  end

  typedef struct packed {
    logic [DW-1:0] res;
    logic          tmo;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command until accepted; returns the acceptance cycle and leaves
  // the caller #1 after the accepting edge.
  task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit tmo, output int t_acc);
    bit   ok = 1'b0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_n     = n;
    cmd_dataa = a;
    cmd_datab = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("cmd_accepted", 32'(ok), 32'd1);
    t_acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      e.res = tmo ? '0 : slave_fn(n, a, b);
      e.tmo = tmo;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for rsp_valid; returns at the negedge of that cycle.
  task automatic wait_valid(output int t_rsp);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rsp_valid_seen", 32'(ok), 32'd1);
    t_rsp = cyc;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, rsp_result, e.res);
      chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.tmo));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: observed=expired required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t, tr, th, w0, r0;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ci_start", 32'(ci_start), 32'd0);
    chk("rst_ci_clk_en", 32'(ci_clk_en), 32'd0);
    chk("rst_ops_cnt", 32'(ops_cnt), 32'd0);
    chk("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic op, latency 3
    lat = 3;
    r0  = start_rises;
    send(8'h01, 32'h0000_00F0, 32'd4, 1'b0, t);
    @(negedge clk);
    chk("basic_start_t1", 32'(ci_start), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("basic_start_t2", 32'(ci_start), 32'd0);
    wait_valid(tr);
    chk("basic_latency", 32'(tr - t), 32'd5);
    chk("basic_result_const", rsp_result, 32'h0000_000F);
    check_rsp("basic");
    chk("basic_start_pulses", 32'(start_rises - r0), 32'd1);
    @(posedge clk);
    #1;
    chk("basic_ops_cnt", 32'(ops_cnt), 32'd1);

    // Combinational slave
    comb_mode = 1'b1;
    w0 = wait_cyc;
    send(8'h02, 32'h1234_5678, 32'hFFFF_0000, 1'b0, t);
    wait_valid(tr);
    chk("comb_latency", 32'(tr - t), 32'd2);
    chk("comb_result_const", rsp_result, 32'hEDCB_5678);
    check_rsp("comb");
    @(posedge clk);
    #1;
    chk("comb_no_wait", 32'(wait_cyc - w0), 32'd0);
    chk("comb_ops_cnt", 32'(ops_cnt), 32'd2);
    comb_mode = 1'b0;

    // Hold during WAIT, latency 4
    lat = 4;
    r0  = start_rises;
    send(8'h01, 32'hABCD_0000, 32'd8, 1'b0, t);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    hold = 1'b1;
    @(negedge clk);
    chk("hold_clk_en_a", 32'(ci_clk_en), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_clk_en_b", 32'(ci_clk_en), 32'd0);
    chk("hold_reissue_start", 32'(ci_start), 32'd1);
    chk("hold_ci_n", 32'(ci_n), 32'h01);
    chk("hold_ci_dataa", ci_dataa, 32'hABCD_0000);
    chk("hold_ci_datab", ci_datab, 32'd8);
    @(posedge clk);
    #1;
    hold = 1'b0;
    wait_valid(tr);
    chk("hold_latency", 32'(tr - t), 32'd10);
    chk("hold_result_const", rsp_result, 32'h00AB_CD00);
    check_rsp("hold");
    chk("hold_start_pulses", 32'(start_rises - r0), 32'd2);
    @(posedge clk);
    #1;
    chk("hold_ops_cnt", 32'(ops_cnt), 32'd3);

    // Watchdog timeout
    never_done = 1'b1;
    w0 = wait_cyc;
    send(8'h01, 32'h0000_0055, 32'd1, 1'b1, t);
    wait_valid(tr);
    chk("tmo_latency", 32'(tr - t), 32'd10);
    check_rsp("tmo");
    @(posedge clk);
    #1;
    chk("tmo_wait_cycles", 32'(wait_cyc - w0), 32'd8);
    chk("tmo_tmo_cnt", 32'(tmo_cnt), 32'd1);
    chk("tmo_ops_cnt", 32'(ops_cnt), 32'd4);
    never_done = 1'b0;

    // Backpressure: rsp_ready low for 5 cycles, second command waiting
    lat = 3;
    rsp_ready = 1'b0;
    send(8'h01, 32'h8000_0000, 32'd31, 1'b0, t);
    wait_valid(tr);
    cmd_valid = 1'b1;
    cmd_n     = 8'h03;
    cmd_dataa = 32'h0F0F_0F0F;
    cmd_datab = 32'h00FF_00FF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", rsp_result, 32'h0000_0001);
      chk("bp_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_rsp("bp_first");
    th = cyc;
    send(8'h03, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, t);
    chk("bp_second_accept", 32'(t - th), 32'd1);
    wait_valid(tr);
    chk("bp_second_result_const", rsp_result, 32'h0FF0_0FF0);
    check_rsp("bp_second");
    @(posedge clk);
    #1;
    chk("bp_ops_cnt", 32'(ops_cnt), 32'd6);

    // Async reset mid-WAIT
    send(8'h01, 32'h0000_000F, 32'd0, 1'b0, t);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("arst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ci_start", 32'(ci_start), 32'd0);
    chk("arst_ci_clk_en", 32'(ci_clk_en), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_ops_cnt", 32'(ops_cnt), 32'd0);
    chk("arst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 32'h0000_0100, 32'd4, 1'b0, t);
    wait_valid(tr);
    chk("post_rst_latency", 32'(tr - t), 32'd5);
    chk("post_rst_result_const", rsp_result, 32'h0000_0010);
    check_rsp("post_rst");
    @(posedge clk);
    #1;
    chk("post_rst_ops_cnt", 32'(ops_cnt), 32'd1);
    chk("post_rst_tmo_cnt", 32'(tmo_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ci_issue_ctrl.md
Name: ci_issue_ctrl

Overview:
- Initiator side of the Nios custom-instruction (CI) multicycle interface.
- Accepts operation requests (n, dataa, datab) on a valid/ready command port.
- Drives start/clk_en/operands into a CI slave (e.g. the shift unit), waits for done with a watchdog, and returns the result on a valid/ready response port.
- Lets fabric masters (test sequencers, DMA helpers) reuse CI accelerators without the CPU.

Parameters:
- DATA_W, 32, operand/result width.
- N_W, 8, width of the CI function select n.
- TIMEOUT, 64, max enabled WAIT cycles before abort; 0 disables the watchdog.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_n  in  N_W  function select
- cmd_dataa  in  DATA_W  operand A
- cmd_datab  in  DATA_W  operand B
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_result  out  DATA_W  CI result, 0 on timeout
- rsp_timeout  out  1  response is a watchdog abort
- hold  in  1  stall request; deasserts ci_clk_en
- ci_clk_en  out  1  CI clock enable
- ci_start  out  1  CI start
- ci_n  out  N_W  to slave
- ci_dataa  out  DATA_W  to slave
- ci_datab  out  DATA_W  to slave
- ci_result  in  DATA_W  from slave
- ci_done  in  1  from slave
- busy  out  1  state != IDLE
- ops_cnt  out  CNT_W  completed ops, wraps
- tmo_cnt  out  CNT_W  timed-out ops, wraps

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All registered outputs 0: rsp_valid, rsp_result, rsp_timeout, ci_n/dataa/datab, ops_cnt, tmo_cnt, watchdog.
  - ci_start=0, ci_clk_en=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1, ci_clk_en=0, ci_start=0.
  - On cmd_valid, latch n/dataa/datab into the ci_* registers and go to ISSUE.
- ISSUE:
  - ci_start=1, ci_clk_en=~hold.
  - If hold=1, remain in ISSUE with start asserted.
  - Otherwise:
    - if ci_done=1 in the same cycle (combinational slave), capture ci_result and go to RESP;
    - else clear the watchdog and go to WAIT.
- WAIT:
  - ci_start=0, ci_clk_en=~hold.
  - ci_done is qualified only when ci_clk_en=1. On a qualified done, capture ci_result, set rsp_timeout=0, go to RESP.
  - hold=1 in WAIT: the slave flushes its sequencer when clk_en is low, so go back to ISSUE and re-issue the same operands. The watchdog is not cleared.
  - Watchdog increments on each enabled WAIT cycle. When it reaches TIMEOUT (TIMEOUT>0), set rsp_result=0 and rsp_timeout=1, then go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1; rsp_result and rsp_timeout stable until rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid.
  - ops_cnt increments on every RESP exit; tmo_cnt additionally increments if rsp_timeout=1. Both wrap at 2^CNT_W.
- ci_n/dataa/datab are held constant from acceptance until RESP exit.
- Latency, for a slave with LATENCY=L≥1 and no hold:
  - command accepted at cycle t;
  - ISSUE at t+1;
  - done seen at t+1+L;
  - rsp_valid at t+2+L.
  - For a combinational slave, rsp_valid at t+2.
- Throughput: one outstanding op. cmd_ready is low outside IDLE, so the minimum period is L+3 cycles.
- reset_n asserted mid-operation aborts immediately with no response, and counters clear.

Decomposition:
- Shared package ci_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - default DATA_W/N_W constants;
  - a TIMEOUT_DISABLED=0 constant.
- One natural sub-module, ci_watchdog: a clearable enabled counter with terminal flag, parameterised by TIMEOUT and disabled when TIMEOUT=0.
- Statistics counters stay inline.

Test Plan:
- Basic op, slave LATENCY=3: cmd n=0x01, a=0x0000_00F0, b=4 accepted at t. Required:
  - ci_start high exactly at t+1;
  - rsp_valid at t+5 with the slave's result;
  - rsp_timeout=0, ops_cnt=1.
- Combinational slave (done in the ISSUE cycle), a=0x1234_5678: rsp_valid at t+2 with the correct result, and no WAIT cycle visited.
- Hold during WAIT, LATENCY=4: hold=1 for 2 cycles at t+3. Required:
  - ci_clk_en=0 during those cycles;
  - return to ISSUE with a second ci_start pulse and unchanged operands;
  - response eventually correct, ops_cnt increments by exactly 1.
- Timeout, TIMEOUT=8, slave never asserts done: rsp_valid after 8 enabled WAIT cycles with rsp_result=0, rsp_timeout=1, tmo_cnt=1.
- Backpressure: rsp_ready low for 5 cycles. Required:
  - rsp_* stable throughout;
  - cmd_ready=0 throughout;
  - second command accepted only the cycle after the rsp_ready handshake.
- Async reset mid-WAIT: reset_n low for 1 cycle. Required:
  - busy, ci_start, ci_clk_en, rsp_valid and counters all 0 immediately;
  - the next command completes normally.
